// File: rtl/uart_apb_master.sv
// uart_apb_master: turns command frames from the UART receive path into single
// APB3 transfers and returns an ack byte (write) or four data bytes (read).
// Frame: CMD (0x57 write / 0x52 read), 4 address bytes, then 4 data bytes for a
// write, all MSB first. Unknown CMD bytes are discarded while idle.
// Optional feature: define UART_APB_TIMEOUT_EN to abort an ACCESS phase that
// waits TIMEOUT cycles without pReady; the response then carries 8'h45 (write)
// or 32'hDEADBEEF (read).
module uart_apb_master #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [7:0]  ACK_BYTE = 8'h4B
) (
    input  logic        pClk,
    input  logic        pReset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        pSel,
    output logic        pEnable,
    output logic        pWrite,
    output logic [31:0] pAddr,
    output logic [31:0] pWdata,
    input  logic [31:0] pReadData,
    input  logic        pReady,
    output logic        busy,
    output logic        rx_overrun
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        SETUP,
        ACCESS,
        RESP
    } stateT;

    stateT       state;
    logic [1:0]  byteCnt;   // position inside the current 4-byte field
    logic [1:0]  txCnt;     // read response bytes already accepted
    logic [31:0] rdShift;   // remaining read bytes, next one in [31:24]

`ifdef UART_APB_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT + 1) < 9) ? 9 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] toCnt;
`endif

    // Anything but IDLE means a frame or transfer is in progress.
    assign busy = (state != IDLE);

    // Frame parser, APB sequencer and response serializer in one registered FSM.
    // NOTE: every state and output register here uses non-blocking assignment so
    // all of them update together from the same pre-edge values.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state      <= IDLE;
            byteCnt    <= 2'd0;
            txCnt      <= 2'd0;
            rdShift    <= 32'd0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'd0;
            pSel       <= 1'b0;
            pEnable    <= 1'b0;
            pWrite     <= 1'b0;
            pAddr      <= 32'd0;
            pWdata     <= 32'd0;
            rx_overrun <= 1'b0;
`ifdef UART_APB_TIMEOUT_EN
            toCnt      <= '0;
`endif
        end else begin
            // Bytes arriving while a transfer or response is in flight are lost.
            rx_overrun <= rx_valid && (state == SETUP || state == ACCESS || state == RESP);

            case (state)
                IDLE: begin
                    if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                        pWrite  <= (rx_data == CMD_WRITE);
                        byteCnt <= 2'd0;
                        state   <= ADDR;
                    end
                end

                ADDR: begin
                    if (rx_valid) begin
                        pAddr   <= {pAddr[23:0], rx_data};
                        byteCnt <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            if (pWrite) begin
                                state <= WDATA;
                            end else begin
                                pSel  <= 1'b1;
                                state <= SETUP;
                            end
                        end
                    end
                end

                WDATA: begin
                    if (rx_valid) begin
                        pWdata  <= {pWdata[23:0], rx_data};
                        byteCnt <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            pSel  <= 1'b1;
                            state <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    pEnable <= 1'b1;
                    state   <= ACCESS;
`ifdef UART_APB_TIMEOUT_EN
                    toCnt   <= '0;
`endif
                end

                ACCESS: begin
                    if (pReady) begin
                        pSel     <= 1'b0;
                        pEnable  <= 1'b0;
                        tx_valid <= 1'b1;
                        txCnt    <= 2'd0;
                        state    <= RESP;
                        if (pWrite) begin
                            tx_data <= ACK_BYTE;
                        end else begin
                            tx_data <= pReadData[31:24];
                            rdShift <= {pReadData[23:0], 8'd0};
                        end
                    end
`ifdef UART_APB_TIMEOUT_EN
                    else if (toCnt == TO_LAST) begin
                        pSel     <= 1'b0;
                        pEnable  <= 1'b0;
                        tx_valid <= 1'b1;
                        txCnt    <= 2'd0;
                        state    <= RESP;
                        if (pWrite) begin
                            tx_data <= 8'h45;
                        end else begin
                            tx_data <= 8'hDE;
                            rdShift <= 32'hADBEEF00;
                        end
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (tx_valid && tx_ready) begin
                        if (pWrite || txCnt == 2'd3) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data <= rdShift[31:24];
                            rdShift <= {rdShift[23:0], 8'd0};
                            txCnt   <= txCnt + 2'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
